// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter and its return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_HOLD,
    SEL_JR,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } sel_t;

  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push writes at wp, pop rewinds wp; when full, a push silently
// overwrites the oldest entry. Top and valid come from registered state only.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     entry [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (do_pop) begin
      wp    <= wp - 1'b1;
      count <= count - 1'b1;
    end else if (do_push) begin
      entry[wp] <= push_data;
      wp        <= wp + 1'b1;
      // Count saturates at DEPTH; the pointer keeps wrapping over the oldest entry.
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end
  end

  assign top_idx = wp - 1'b1;
  assign valid   = (count != '0);
  assign top     = valid ? entry[top_idx] : '0;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: flush/stall/jr/jump/branch/sequential next-PC priority,
// sticky misalignment flag on jr/flush targets, and a return-address stack for call/return.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT),
  parameter int                RAS_DEPTH = 4,
  parameter int                IMM_W     = 16,
  parameter int                JADDR_W   = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target,
  input  logic               is_jmp,
  input  logic               is_jal,
  input  logic               is_jr,
  input  logic               is_ret,
  input  logic               is_br,
  input  logic [IMM_W-1:0]   imm,
  input  logic [JADDR_W-1:0] jmp_addr,
  input  logic [ADDR_W-1:0]  rrs,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [ADDR_W-1:0]  ras_top,
  output logic               ras_valid,
  output logic               misalign
);

  sel_t              sel;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_target;
  logic              misalign_set;

  assign pc_plus4   = pc + ADDR_W'(PC_STEP);
  assign br_off     = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << 2;
  assign jmp_target = {pc_plus4[ADDR_W-1:JADDR_W+2], jmp_addr, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (flush)       sel = SEL_FLUSH;
    else if (stall)  sel = SEL_HOLD;
    else if (is_jr)  sel = SEL_JR;
    else if (is_jmp) sel = SEL_JMP;
    else if (is_br)  sel = SEL_BR;
  end

  // Register/flush targets are used as given apart from the low two bits, which are dropped.
  always_comb begin
    next_pc      = pc_plus4;
    misalign_set = 1'b0;
    case (sel)
      SEL_FLUSH: begin
        next_pc      = {flush_target[ADDR_W-1:2], 2'b00};
        misalign_set = (flush_target[1:0] != 2'b00);
      end
      SEL_HOLD: next_pc = pc;
      SEL_JR: begin
        next_pc      = {rrs[ADDR_W-1:2], 2'b00};
        misalign_set = (rrs[1:0] != 2'b00);
      end
      SEL_JMP: next_pc = jmp_target;
      SEL_BR:  next_pc = pc_plus4 + br_off;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      pc <= next_pc;
      if (misalign_set) misalign <= 1'b1;
    end
  end

  // Selecting jr/jump already implies !flush && !stall, and jr outranks jump, so pop wins.
  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      ((sel == SEL_JMP) && is_jal),
    .pop       ((sel == SEL_JR) && is_ret),
    .push_data (pc_plus4),
    .top       (ras_top),
    .valid     (ras_valid)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a queue-based reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, is_jmp, is_jal, is_jr, is_ret, is_br;
  logic [31:0] flush_target, rrs;
  logic [15:0] imm;
  logic [25:0] jmp_addr;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, misalign;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_mis;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W    (32),
    .RESET_VEC (32'h100),
    .RAS_DEPTH (4),
    .IMM_W     (16),
    .JADDR_W   (26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .is_jmp       (is_jmp),
    .is_jal       (is_jal),
    .is_jr        (is_jr),
    .is_ret       (is_ret),
    .is_br        (is_br),
    .imm          (imm),
    .jmp_addr     (jmp_addr),
    .rrs          (rrs),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .ras_top      (ras_top),
    .ras_valid    (ras_valid),
    .misalign     (misalign)
  );

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] p4;
    int          s;
    if (!rst_n) begin
      m_pc  = 32'h100;
      m_ras = {};
      m_mis = 1'b0;
    end else begin
      p4 = m_pc + 32'd4;
      if (flush) begin
        m_pc = flush_target & ~32'd3;
        if (flush_target % 4 != 0) m_mis = 1'b1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (is_jr) begin
        m_pc = rrs & ~32'd3;
        if (rrs % 4 != 0) m_mis = 1'b1;
        if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      end else if (is_jmp) begin
        m_pc = (p4 & 32'hF000_0000) | (32'(jmp_addr) * 4);
        if (is_jal) begin
          m_ras.push_back(p4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end else if (is_br) begin
        s    = $signed(imm);
        m_pc = p4 + 32'(s * 4);
      end else begin
        m_pc = p4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("model_ras_valid", 32'(ras_valid), 32'(m_ras.size() != 0));
      chk("model_ras_top", ras_top, (m_ras.size() != 0) ? m_ras[$] : 32'd0);
      chk("model_misalign", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic idle();
    stall = 0; flush = 0; is_jmp = 0; is_jal = 0; is_jr = 0; is_ret = 0; is_br = 0;
    flush_target = '0; rrs = '0; imm = '0; jmp_addr = '0;
  endtask

  // One clock: inputs set before the call are sampled at the edge, then cleared.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush = 1; flush_target = t; cyc();
  endtask

  task automatic do_call(input logic [25:0] a);
    is_jmp = 1; is_jal = 1; jmp_addr = a; cyc();
  endtask

  task automatic do_ret(input logic [31:0] r);
    is_jr = 1; is_ret = 1; rrs = r; cyc();
  endtask

  initial begin
    logic [31:0] exp_ret [5];
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h100);
    chk("reset_ras_valid", 32'(ras_valid), 32'd0);
    chk("reset_ras_top", ras_top, 32'd0);
    chk("reset_misalign", 32'(misalign), 32'd0);
    #2 rst_n = 1;
    cmp_en = 1;

    cyc(); chk("seq1", pc, 32'h104);
    cyc(); chk("seq2", pc, 32'h108);
    cyc(); chk("seq3", pc, 32'h10C);
    chk("seq_ras_valid", 32'(ras_valid), 32'd0);

    do_flush(32'h200);
    is_br = 1; imm = 16'hFFFE; cyc(); chk("br_neg", pc, 32'h1FC);
    do_flush(32'h200);
    is_br = 1; imm = 16'h0003; cyc(); chk("br_pos", pc, 32'h210);

    do_flush(32'h0040_0010);
    do_call(26'h40);
    chk("call_pc", pc, 32'h100);
    chk("call_ras_top", ras_top, 32'h0040_0014);
    chk("call_ras_valid", 32'(ras_valid), 32'd1);
    do_ret(32'h0040_0014);
    chk("ret_pc", pc, 32'h0040_0014);
    chk("ret_ras_valid", 32'(ras_valid), 32'd0);

    exp_ret = '{32'h0040_0018, 32'h404, 32'h804, 32'hC04, 32'h1004};
    for (int i = 0; i < 5; i++) do_call(26'((i + 1) * 32'h100));
    chk("full_pc", pc, 32'h1400);
    for (int i = 4; i >= 1; i--) begin
      chk("pop_top", ras_top, exp_ret[i]);
      do_ret(exp_ret[i]);
      chk("pop_pc", pc, exp_ret[i]);
    end
    chk("empty_ras_top", ras_top, 32'd0);
    chk("empty_ras_valid", 32'(ras_valid), 32'd0);
    do_ret(32'h2000);
    chk("pop_empty_top", ras_top, 32'd0);
    chk("pop_empty_pc", pc, 32'h2000);

    do_flush(32'h5000);
    do_call(26'h10);
    chk("pre_stall_pc", pc, 32'h40);
    for (int i = 0; i < 2; i++) begin
      stall = 1; is_br = 1; imm = 16'h0005; cyc();
    end
    chk("stall_pc", pc, 32'h40);
    chk("stall_ras_top", ras_top, 32'h5004);

    stall = 1; flush = 1; flush_target = 32'h3002; is_jmp = 1; is_jal = 1; cyc();
    chk("flush_pc", pc, 32'h3000);
    chk("flush_misalign", 32'(misalign), 32'd1);
    chk("flush_ras_top", ras_top, 32'h5004);
    cyc(); cyc();
    chk("sticky_pc", pc, 32'h3008);
    chk("sticky_misalign", 32'(misalign), 32'd1);

    do_flush(32'h6000);
    do_call(26'h20); do_call(26'h40); do_call(26'h60);
    chk("pre_rst_top", ras_top, 32'h104);
    #2 rst_n = 0;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_ras_valid", 32'(ras_valid), 32'd0);
    chk("arst_ras_top", ras_top, 32'd0);
    chk("arst_misalign", 32'(misalign), 32'd0);
    @(posedge clk);
    #3 rst_n = 1;
    cyc(); chk("post_rst1", pc, 32'h104);
    cyc(); chk("post_rst2", pc, 32'h108);

    for (int n = 0; n < 3000; n++) begin
      flush  = ($urandom_range(15) == 0);
      flush_target = $urandom();
      if ($urandom_range(3) != 0) flush_target[1:0] = 2'b00;
      stall  = ($urandom_range(7) == 0);
      is_jr  = ($urandom_range(7) == 0);
      is_ret = is_jr && $urandom_range(1);
      rrs    = ($urandom_range(1) && m_ras.size() != 0) ? m_ras[$] : $urandom();
      if ($urandom_range(7) != 0) rrs[1:0] = 2'b00;
      is_jmp = ($urandom_range(5) == 0);
      is_jal = is_jmp && !is_jr && $urandom_range(1);
      is_br  = ($urandom_range(3) == 0);
      imm    = 16'($urandom());
      jmp_addr = 26'($urandom());
      if (n == 1500) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      cyc();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the fetch stage; successor to the single-width, flush-less PC.
- Adds async reset to a programmable vector, a stall/flush pipeline interface, sign-extended branch offsets, misalignment detection and a circular return-address stack (RAS) for call/return.
- Sits between the hazard unit/decode (control inputs) and instruction memory (drives `pc`).

Parameters:
- ADDR_W, 32, PC width in bits; legal range ≥ 32.
- RESET_VEC, 0, PC value after reset; must be word aligned.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥ 2.
- IMM_W, 16, branch immediate width.
- JADDR_W, 26, jump index width; ADDR_W-4 ≥ JADDR_W+2 is not required, concatenation fixed below.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC (bubble); no state change except flush.
- flush  in  1  redirect from a later stage; overrides stall.
- flush_target  in  ADDR_W  redirect address.
- is_jmp  in  1  absolute jump (j/jal).
- is_jal  in  1  call: push return address; valid only with is_jmp.
- is_jr  in  1  register jump.
- is_ret  in  1  jr through link register: pop RAS; valid only with is_jr.
- is_br  in  1  branch taken.
- imm  in  IMM_W  branch word offset, signed.
- jmp_addr  in  JADDR_W  jump word index.
- rrs  in  ADDR_W  register value for jr.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc + 4, combinational.
- ras_top  out  ADDR_W  top RAS entry; 0 when empty.
- ras_valid  out  1  RAS non-empty.
- misalign  out  1  sticky: a jr/flush target had non-zero bits [1:0].

Behaviour:
- Reset (async assert, sync deassert handled externally): pc=RESET_VEC, RAS count=0, write pointer=0, all entries 0, misalign=0, ras_valid=0, ras_top=0.
- One update per rising edge.
- Next-PC priority, highest first:
  1. flush → flush_target.
  2. stall → hold pc.
  3. is_jr → rrs.
  4. is_jmp → {pc_plus4[ADDR_W-1:JADDR_W+2], jmp_addr, 2'b00}.
  5. is_br → pc_plus4 + (sign_extend(imm) << 2).
  6. Otherwise → pc_plus4.
- No "-4" correction on jr; target is used as given.
- Arithmetic is modulo 2^ADDR_W: wrap from all-ones+4 to 3→... no saturation, no flag.
- Target alignment:
  - For flush and jr, bits [1:0] of the target are forced to 0 when loaded into pc.
  - If those bits were non-zero, misalign sets the following cycle and stays set until reset.
- Illegal input combinations (is_jmp with is_jr, etc.) are resolved by the priority above, with no error.
- RAS updates are qualified by !flush && !stall:
  - Push (is_jmp && is_jal): entry[wp] = pc_plus4, wp = wp+1 mod RAS_DEPTH, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten silently.
  - Pop (is_jr && is_ret && count>0): wp = wp-1, count = count-1.
  - Pop when empty: no change.
  - Push and pop in the same cycle cannot occur, because jr has priority and jal requires is_jmp. If both flags are asserted, the pop wins and the push is dropped.
- ras_top = entry[wp-1] when count>0, else 0; ras_valid = (count != 0). Both are registered-state derived with no input-to-output path.
- Flush and stall asserted together: flush wins; RAS unchanged.
- Reset asserted mid-operation: state clears immediately, regardless of clock.
- Latency:
  - pc reflects the control inputs one cycle after the edge where they are sampled.
  - pc_plus4 follows pc combinationally.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC select enum (SEL_FLUSH, SEL_HOLD, SEL_JR, SEL_JMP, SEL_BR, SEL_SEQ);
  - constant PC_STEP = 4;
  - the default reset vector.
- One sub-module: ras_stack (parametrised circular stack with push/pop/top/valid, full-overwrite semantics), instantiated once.
- Next-PC mux and alignment check stay inline.

Test Plan:
- Reset with RESET_VEC=0x100, then 3 free-running clocks → pc = 0x100, 0x104, 0x108, 0x10C; ras_valid=0.
- pc=0x200, is_br=1, imm=0xFFFE → pc=0x1FC. With imm=0x0003 from pc=0x200 → pc=0x210.
- Call/return:
  - pc=0x00400010, is_jmp=is_jal=1, jmp_addr=0x0000040 → pc=0x00000100, ras_top=0x00400014, ras_valid=1.
  - Later, is_jr=is_ret=1, rrs=0x00400014 → pc=0x00400014, ras_valid=0.
- RAS_DEPTH=4, five pushes of returns A..E → count stays 4; successive pops give E, D, C, B; the fifth pop finds the stack empty and ras_top=0.
- Stall and flush:
  - stall=1 with is_br=1 for 2 cycles → pc held and RAS unchanged.
  - stall=1, flush=1, flush_target=0x3002 → pc=0x3000 and misalign=1 next cycle; misalign stays set through later normal cycles.
- Async reset:
  - rst_n dropped between clock edges while the RAS holds 3 entries → pc=RESET_VEC and ras_valid=0 before the next edge.
  - After rst_n release, pc increments normally.
